// File: rtl/serial_add_pkg.sv
// Shared types and width helpers for the serial multi-precision adder scheduler.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int beat_w(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// Requester and result handshake bundle for serial_add_sched.
interface serial_add_sched_if
  import serial_add_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int BEATS = 4,
  parameter int NREQ  = 3
);
  localparam int W   = SIZE * BEATS;
  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ci;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_co;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_ci, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ci, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id
  );
endinterface

// File: rtl/add_slice.sv
// Combinational SIZE-bit ripple-carry adder built from per-bit gates.
module add_slice #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  output logic [SIZE-1:0] sum,
  output logic            co
);

  // Each bit keeps its own carry net so the chain is not one self-referencing vector.
  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    logic cin;
    logic p;
    logic cout;
    if (i == 0) begin : g_first
      assign cin = ci;
    end else begin : g_next
      assign cin = g_bit[i-1].cout;
    end
    assign p      = a[i] ^ b[i];
    assign sum[i] = p ^ cin;
    assign cout   = (a[i] & b[i]) | (p & cin);
  end

  assign co = g_bit[SIZE-1].cout;

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one SIZE-bit adder slice across NREQ requesters;
// each W-bit add runs over BEATS cycles, carry chained through a register.
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int BEATS = 4,
  parameter int NREQ  = 3
) (
  input logic               clk,
  input logic               rst,
  serial_add_sched_if.slave bus
);

  localparam int W   = SIZE * BEATS;
  localparam int IDW = idw(NREQ);
  localparam int BW  = beat_w(BEATS);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, co_q, co_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [IDW-1:0]  id_q, id_d, rr_q, rr_d;
  logic [IDW-1:0]  grant;
  logic            grant_found;
  logic [NREQ-1:0] ready_c;
  logic [SIZE-1:0] sl_a, sl_b, sl_s;
  logic            sl_co;

  // First pass covers rr_q..NREQ-1; second pass wraps to the low indices.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_found && bus.req_valid[j] && (j >= int'(rr_q))) begin
        grant_found = 1'b1;
        grant       = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_found && bus.req_valid[j]) begin
        grant_found = 1'b1;
        grant       = IDW'(j);
      end
    end
  end

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BW'(k)) begin
        sl_a = a_q[k*SIZE +: SIZE];
        sl_b = b_q[k*SIZE +: SIZE];
      end
    end
  end

  add_slice #(.SIZE(SIZE)) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .ci  (carry_q),
    .sum (sl_s),
    .co  (sl_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    beat_d  = beat_q;
    id_d    = id_q;
    rr_d    = rr_q;
    ready_c = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          ready_c = NREQ'(1) << grant;
          for (int j = 0; j < NREQ; j++) begin
            if (grant == IDW'(j)) begin
              a_d     = bus.req_a[j*W +: W];
              b_d     = bus.req_b[j*W +: W];
              carry_d = bus.req_ci[j];
            end
          end
          id_d    = grant;
          beat_d  = '0;
          sum_d   = '0;
          rr_d    = (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < BEATS; k++) begin
          if (beat_q == BW'(k)) sum_d[k*SIZE +: SIZE] = sl_s;
        end
        carry_d = sl_co;
        beat_d  = beat_q + 1'b1;
        if (beat_q == BW'(BEATS-1)) begin
          co_d    = sl_co;
          beat_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      beat_q  <= '0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      beat_q  <= beat_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = (state_q == HOLD);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_co    = co_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: transaction-level reference model
// compared every cycle, directed corner cases, then randomized traffic.
module tb_serial_add_sched;

  localparam int SIZE  = 4;
  localparam int BEATS = 4;
  localparam int NREQ  = 3;
  localparam int W     = SIZE * BEATS;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  bit   chk_en = 1'b0;

  // Reference model: phase flags, completed-beat count, expected W+1 bit result.
  bit           m_busy = 1'b0;
  bit           m_hold = 1'b0;
  bit           m_fresh = 1'b0;
  int           m_done = 0;
  int           m_rr = 0;
  int           m_id = 0;
  logic [W:0]   m_res = '0;

  int expOrder[6] = '{0, 1, 2, 0, 1, 2};

  serial_add_sched_if #(.SIZE(SIZE), .BEATS(BEATS), .NREQ(NREQ)) bus ();

  serial_add_sched #(.SIZE(SIZE), .BEATS(BEATS), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    int r;
    logic [NREQ-1:0] s;
    r = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr + k) % NREQ;
      s = v >> idx;
      if (r < 0 && s[0]) r = idx;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] slot(input logic [NREQ*W-1:0] v, input int i);
    logic [NREQ*W-1:0] s;
    s = v >> (i * W);
    return s[W-1:0];
  endfunction

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (v[j]) r = j;
    end
    return r;
  endfunction

  // Compare DUT against the model, then advance the model by one clock.
  always @(negedge clk) begin : compare
    logic [NREQ-1:0] expReady;
    logic [NREQ-1:0] cis;
    logic [W-1:0]    mask;
    int              g;
    expReady = '0;
    g = -1;
    if (!m_busy && !m_hold) begin
      g = pick(bus.req_valid, m_rr);
      if (g >= 0) expReady = NREQ'(1) << g;
    end
    if (chk_en) begin
      checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(m_hold));
      if (m_hold) begin
        checkOutput("rsp_sum", 32'(bus.rsp_sum), 32'(m_res[W-1:0]));
        checkOutput("rsp_co", 32'(bus.rsp_co), 32'(m_res[W]));
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      end else if (m_busy) begin
        mask = (m_done == 0) ? '0 : ({W{1'b1}} >> (W - m_done * SIZE));
        checkOutput("partial_sum", 32'(bus.rsp_sum), 32'(m_res[W-1:0] & mask));
        checkOutput("run_id", 32'(bus.rsp_id), 32'(m_id));
      end else if (m_fresh) begin
        checkOutput("reset_sum", 32'(bus.rsp_sum), 32'd0);
        checkOutput("reset_co", 32'(bus.rsp_co), 32'd0);
        checkOutput("reset_id", 32'(bus.rsp_id), 32'd0);
      end
    end
    m_fresh = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      m_hold  = 1'b0;
      m_rr    = 0;
      m_fresh = 1'b1;
    end else if (g >= 0) begin
      cis    = bus.req_ci >> g;
      m_res  = (W+1)'(slot(bus.req_a, g)) + (W+1)'(slot(bus.req_b, g)) + (W+1)'(cis[0]);
      m_id   = g;
      m_rr   = (g + 1) % NREQ;
      m_busy = 1'b1;
      m_done = 0;
    end else if (m_busy) begin
      m_done++;
      if (m_done == BEATS) begin
        m_busy = 1'b0;
        m_hold = 1'b1;
      end
    end else if (m_hold && bus.rsp_ready) begin
      m_hold = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                               input logic [NREQ*W-1:0] b, input logic [NREQ-1:0] ci,
                               input logic rdy);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_ci    = ci;
    bus.rsp_ready = rdy;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issue one request set, wait for accept and result (both bounded).
  task automatic runOp(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                       input logic [NREQ*W-1:0] b, input logic [NREQ-1:0] ci, input logic rdy,
                       output int gid, output logic [W-1:0] sum, output logic co,
                       output int rid, output int lat);
    int tAcc;
    bit got;
    gid = -1; sum = '0; co = 1'b0; rid = -1; lat = -1; tAcc = 0;
    applyStimulus(v, a, b, ci, rdy);
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        got  = 1'b1;
        tAcc = cyc;
        gid  = oh2idx(bus.req_ready);
      end
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    else begin
      applyStimulus('0, a, b, ci, rdy);
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (bus.rsp_valid) begin
          got = 1'b1;
          sum = bus.rsp_sum;
          co  = bus.rsp_co;
          rid = int'(bus.rsp_id);
          lat = cyc - tAcc;
        end
      end
      if (!got) checkOutput("response_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin : main
    int gid, rid, lat, nAcc, lastCyc;
    logic [W-1:0] sum;
    logic co;
    bit got;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_ci = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("post_reset_ready", 32'(bus.req_ready), 32'd0);

    runOp(3'b001, {16'h0, 16'h0, 16'h1234}, {16'h0, 16'h0, 16'h0FFF}, 3'b000, 1'b1,
          gid, sum, co, rid, lat);
    checkOutput("basic_grant", 32'(gid), 32'd0);
    checkOutput("basic_sum", 32'(sum), 32'h2233);
    checkOutput("basic_co", 32'(co), 32'd0);
    checkOutput("basic_id", 32'(rid), 32'd0);
    checkOutput("basic_latency", 32'(lat), 32'd5);

    runOp(3'b100, {16'hFFFF, 16'h0, 16'h0}, {16'h0, 16'h0, 16'h0}, 3'b100, 1'b1,
          gid, sum, co, rid, lat);
    checkOutput("chain_grant", 32'(gid), 32'd2);
    checkOutput("chain_sum", 32'(sum), 32'h0000);
    checkOutput("chain_co", 32'(co), 32'd1);
    runOp(3'b001, {16'h0, 16'h0, 16'h8000}, {16'h0, 16'h0, 16'h8000}, 3'b000, 1'b1,
          gid, sum, co, rid, lat);
    checkOutput("msb_sum", 32'(sum), 32'h0000);
    checkOutput("msb_co", 32'(co), 32'd1);

    runOp(3'b010, {16'h0, 16'h00FF, 16'h0}, {16'h0, 16'h0001, 16'h0}, 3'b000, 1'b1,
          gid, sum, co, rid, lat);
    checkOutput("r1_sum", 32'(sum), 32'h0100);
    runOp(3'b010, {16'h0, 16'hAAAA, 16'h0}, {16'h0, 16'h5555, 16'h0}, 3'b010, 1'b1,
          gid, sum, co, rid, lat);
    checkOutput("wrap_grant", 32'(gid), 32'd1);
    checkOutput("wrap_sum", 32'(sum), 32'h0000);
    checkOutput("wrap_co", 32'(co), 32'd1);

    runOp(3'b111, {16'h0003, 16'h0002, 16'h0001}, {16'h0030, 16'h0020, 16'h0010}, 3'b000, 1'b0,
          gid, sum, co, rid, lat);
    checkOutput("bp_grant", 32'(gid), 32'd2);
    checkOutput("bp_sum", 32'(sum), 32'h0033);
    applyStimulus(3'b111, {16'h0003, 16'h0002, 16'h0001}, {16'h0030, 16'h0020, 16'h0010},
                  3'b000, 1'b0);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      checkOutput("bp_ready_low", 32'(bus.req_ready), 32'd0);
      checkOutput("bp_valid_held", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_sum_stable", 32'(bus.rsp_sum), 32'h0033);
    end
    applyStimulus(3'b111, {16'h0003, 16'h0002, 16'h0001}, {16'h0030, 16'h0020, 16'h0010},
                  3'b000, 1'b1);
    @(negedge clk);
    checkOutput("hs_cycle_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("after_hs_ready", 32'(bus.req_ready), 32'b001);
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        checkOutput("after_hs_sum", 32'(bus.rsp_sum), 32'h0011);
        checkOutput("after_hs_id", 32'(bus.rsp_id), 32'd0);
      end
    end
    if (!got) checkOutput("after_hs_timeout", 32'd0, 32'd1);

    doReset();
    applyStimulus(3'b111, {16'h0300, 16'h0020, 16'h0001}, {16'h0400, 16'h0050, 16'h0006},
                  3'b000, 1'b1);
    nAcc = 0;
    lastCyc = 0;
    for (int t = 0; t < 80 && nAcc < 6; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        checkOutput("fair_order", 32'(oh2idx(bus.req_ready)), 32'(expOrder[nAcc]));
        if (nAcc > 0) checkOutput("fair_spacing", 32'(cyc - lastCyc), 32'd6);
        lastCyc = cyc;
        nAcc++;
      end
    end
    checkOutput("fair_count", 32'(nAcc), 32'd6);
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    repeat (8) @(posedge clk);

    applyStimulus(3'b001, {16'h0, 16'h0, 16'h4321}, {16'h0, 16'h0, 16'h1111}, 3'b000, 1'b1);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) got = 1'b1;
    end
    if (!got) checkOutput("abort_accept_timeout", 32'd0, 32'd1);
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("abort_sum", 32'(bus.rsp_sum), 32'd0);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    runOp(3'b111, {16'h000F, 16'h00F0, 16'h0F00}, {16'h0001, 16'h0010, 16'h0100}, 3'b000, 1'b1,
          gid, sum, co, rid, lat);
    checkOutput("fresh_grant", 32'(gid), 32'd0);
    checkOutput("fresh_sum", 32'(sum), 32'h1000);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 399) == 0);
      bus.req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      bus.req_a     = (NREQ*W)'({$urandom, $urandom});
      bus.req_b     = (NREQ*W)'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) bus.req_b = ~bus.req_a;
      bus.req_ci    = NREQ'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Round-robin scheduler that time-shares one SIZE-bit ripple-carry adder slice among NREQ requesters.
- Each request is a multi-precision add of width W = SIZE*BEATS. The block sequences it over BEATS cycles, least-significant slice first, and chains the carry through a register between beats.
- Sits between requester ports and a single result port, with valid/ready handshakes on both sides.

Parameters:
- SIZE, 4, width of the shared adder slice in bits.
- BEATS, 4, slices per operand; W = SIZE*BEATS (16 by default).
- NREQ, 3, number of requesters; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  packed operand B, same packing as req_a.
- req_ci  input  NREQ  per-requester carry-in.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result consumer ready.
- rsp_sum  output  W  sum, modulo 2^W.
- rsp_co  output  1  carry out of bit W-1.
- rsp_id  output  IDW  index of the granted requester; IDW = max(1, clog2(NREQ)).

Behaviour:
- Reset values: state IDLE, rr_ptr = 0, req_ready = 0, rsp_valid = 0, rsp_sum = 0, rsp_co = 0, rsp_id = 0, beat = 0, carry = 0.
- States: IDLE, RUN, HOLD.
- IDLE, grant selection:
  - g is the first index with req_valid set, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[g] = 1 combinationally in the same cycle; this is the handshake.
  - All other req_ready bits stay 0. req_ready is 0 outside IDLE.
- IDLE, on accept:
  - Capture a, b and id = g.
  - Set carry = req_ci[g], beat = 0, rsp_sum = 0.
  - Set rr_ptr = (g+1) mod NREQ. Go to RUN.
- IDLE with no req_valid bit set: stay in IDLE; rr_ptr unchanged.
- RUN, each cycle:
  - slice k = beat.
  - {cout, s} = a[k*SIZE +: SIZE] + b[k*SIZE +: SIZE] + carry.
  - Write rsp_sum[k*SIZE +: SIZE] = s; set carry = cout; beat += 1.
  - On beat == BEATS-1: also set rsp_co = cout, go to HOLD, set rsp_valid = 1.
- Latency: accept in cycle T gives RUN in cycles T+1..T+BEATS and rsp_valid high from cycle T+BEATS+1.
- HOLD:
  - rsp_valid = 1; rsp_sum, rsp_co and rsp_id are stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid = 0, go to IDLE.
  - No new accept occurs in the handshake cycle. Back-to-back throughput is one op per BEATS+2 cycles.
- Requester rules: a requester may drop req_valid before it is granted; nothing is captured and no error is raised. Operands are sampled only on the accept cycle.
- Arithmetic: unsigned, modulo 2^W. Carry propagates across slices only through the carry register, never combinationally across beats.
- Reset mid-operation: any in-flight op is discarded. All outputs return to reset values on the following cycle, and no response is ever emitted for the aborted op.
- NREQ = 1: rr_ptr stays 0; behaviour is otherwise identical.
- rsp_ready may be high in any state; it is ignored outside HOLD.

Decomposition:
- Package serial_add_pkg:
  - state enum {IDLE, RUN, HOLD}.
  - clog2-based IDW function.
  - Beat counter width localparam helper.
- Sub-module add_slice: combinational SIZE-bit ripple-carry slice with inputs a, b, ci and outputs sum, co. It is built from generate-loop per-bit xor/and/or gates and is instantiated once.

Test Plan:
- Basic add: req_valid = 001, a0 = 0x1234, b0 = 0x0FFF, ci = 0, rsp_ready = 1 -> req_ready[0] high in the accept cycle T; rsp_valid at T+5; rsp_sum = 0x2233, rsp_co = 0, rsp_id = 0.
- Full carry chain: a0 = 0xFFFF, b0 = 0x0000, ci = 1 -> rsp_sum = 0x0000, rsp_co = 1; also a = 0x8000, b = 0x8000, ci = 0 -> sum 0x0000, co 1.
- Fairness: req_valid = 111 held with rsp_ready = 1 -> grant order 0, 1, 2, 0, 1, 2; consecutive accepts exactly 6 cycles apart; each rsp_id matches.
- Wrap search: after a grant to requester 1 (rr_ptr = 2), assert only req_valid = 010 -> requester 1 granted again; rr_ptr becomes 2.
- Backpressure: rsp_ready = 0 for 10 cycles after rsp_valid -> outputs stable, req_ready = 000 throughout; rsp_ready = 1 -> handshake, next accept one cycle later.
- Reset mid-RUN: assert rst at beat 2 -> next cycle rsp_valid = 0, rsp_sum = 0, rr_ptr = 0, no response for the aborted op; a fresh request afterwards completes correctly.
